// File: rtl/dma_pkg.sv
// Shared DMA types and default widths for the arbiter, DMA controller and
// layer sequencing FSMs.
package dma_pkg;

  localparam int unsigned DMA_NUM_REQ = 4;
  localparam int unsigned DMA_ADDR_W  = 32;
  localparam int unsigned DMA_LEN_W   = 16;
  localparam int unsigned DMA_TIMEOUT = 4096;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RELEASE
  } arb_state_t;

  typedef struct packed {
    logic [DMA_ADDR_W-1:0] addr;
    logic [DMA_LEN_W-1:0]  len;
    logic                  wr;
  } dma_desc_t;

  // Index of the set bit in a one-hot vector of up to 8 requesters.
  function automatic int unsigned oh2idx(input logic [7:0] oh);
    int unsigned idx;
    idx = 0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (oh[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/dma_req_arbiter_rr_pick.sv
// Combinational round-robin priority encoder: first set req bit at or above
// rrPtr, wrapping around.
module rr_pick #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   rrPtr,
  output logic [NUM_REQ-1:0] win,
  output logic               valid
);

  logic [PTR_W-1:0] idx;

  always_comb begin
    win   = '0;
    valid = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = PTR_W'((32'(rrPtr) + i) % NUM_REQ);
      if (!valid && req[idx]) begin
        win[idx] = 1'b1;
        valid    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dma_req_arbiter.sv
// Round-robin arbiter sharing one DMA channel between NUM_REQ requesters,
// with descriptor latching, single start pulse and a completion watchdog.
module dma_req_arbiter
  import dma_pkg::*;
#(
  parameter int unsigned NUM_REQ = DMA_NUM_REQ,
  parameter int unsigned ADDR_W  = DMA_ADDR_W,
  parameter int unsigned LEN_W   = DMA_LEN_W,
  parameter int unsigned TIMEOUT = DMA_TIMEOUT
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ-1:0][LEN_W-1:0]  req_len,
  input  logic [NUM_REQ-1:0]             req_wr,
  output logic [NUM_REQ-1:0]             gnt,
  output logic [NUM_REQ-1:0]             done,
  output logic                           err,
  output logic                           dma_start,
  output logic [ADDR_W-1:0]              dma_addr,
  output logic [LEN_W-1:0]               dma_len,
  output logic                           dma_wr,
  output logic                           dma_abort,
  input  logic                           dma_done,
  input  logic                           dma_err
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned WD_W  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  arb_state_t state, nextState;

  logic [PTR_W-1:0]   rrPtr, gntIdx, winIdx;
  logic [NUM_REQ-1:0] winOh;
  logic               winValid, winZeroLen;
  logic [WD_W-1:0]    wdog;
  logic               expire, zlHold;
  logic [NUM_REQ-1:0] doneD;
  logic               errD, startD, abortD;

  rr_pick #(
    .NUM_REQ(NUM_REQ),
    .PTR_W  (PTR_W)
  ) uPick (
    .req  (req),
    .rrPtr(rrPtr),
    .win  (winOh),
    .valid(winValid)
  );

  always_comb begin
    winIdx     = PTR_W'(oh2idx(8'(winOh)));
    winZeroLen = (req_len[winIdx] == '0);
    expire     = (state == WAIT) && !dma_done && (wdog == WD_W'(TIMEOUT - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nextState;
  end

  // Zero-length grants spend two cycles in RELEASE (zlHold) so done lands
  // in the second granted cycle, matching the grant-then-release timing.
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (winValid) nextState = winZeroLen ? RELEASE : ISSUE;
      ISSUE:   nextState = WAIT;
      WAIT:    if (dma_done || expire) nextState = RELEASE;
      RELEASE: if (!zlHold) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    startD = (state == IDLE) && winValid && !winZeroLen;
    abortD = expire;
    doneD  = '0;
    errD   = 1'b0;
    if (state == WAIT && (dma_done || expire)) begin
      doneD = gnt;
      errD  = dma_done ? dma_err : 1'b1;
    end
    if (state == RELEASE && zlHold) doneD = gnt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt       <= '0;
      done      <= '0;
      err       <= 1'b0;
      dma_start <= 1'b0;
      dma_abort <= 1'b0;
      dma_addr  <= '0;
      dma_len   <= '0;
      dma_wr    <= 1'b0;
      rrPtr     <= '0;
      gntIdx    <= '0;
      wdog      <= '0;
      zlHold    <= 1'b0;
    end else begin
      done      <= doneD;
      err       <= errD;
      dma_start <= startD;
      dma_abort <= abortD;
      case (state)
        IDLE: if (winValid) begin
          gnt      <= winOh;
          gntIdx   <= winIdx;
          dma_addr <= req_addr[winIdx];
          dma_len  <= req_len[winIdx];
          dma_wr   <= req_wr[winIdx];
          zlHold   <= winZeroLen;
        end
        ISSUE: wdog <= '0;
        WAIT:  wdog <= wdog + 1'b1;
        RELEASE: begin
          if (zlHold) begin
            zlHold <= 1'b0;
          end else begin
            gnt   <= '0;
            rrPtr <= (gntIdx == PTR_W'(NUM_REQ - 1)) ? '0 : gntIdx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/dma_req_arbiter.md
# dma_req_arbiter

Shares the accelerator's single DMA channel between up to NUM_REQ transfer requesters: weight loader, bias loader, image loader and output writeback. It picks one pending request with round-robin priority and latches that requester's descriptor. It then issues one start pulse to the DMA engine and holds the grant until the engine reports completion or a watchdog expires. It sits between the layer sequencing FSMs and the DMA controller.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- ADDR_W, 32, memory address width
- LEN_W, 16, transfer length in words
- TIMEOUT, 4096, watchdog limit in cycles spent in WAIT
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- req  in  NUM_REQ  per-requester transfer request (level)
- req_addr  in  NUM_REQ x ADDR_W  per-requester start address
- req_len  in  NUM_REQ x LEN_W  per-requester length in words
- req_wr  in  NUM_REQ  per-requester direction (1 = write to memory)
- gnt  out  NUM_REQ  one-hot grant, held for the whole transaction
- done  out  NUM_REQ  one-cycle completion pulse to the granted requester
- err  out  1  one-cycle pulse, coincident with done, on DMA error or timeout
- dma_start  out  1  one-cycle transfer start
- dma_addr  out  ADDR_W  latched address, valid while gnt is nonzero
- dma_len  out  LEN_W  latched length
- dma_wr  out  1  latched direction
- dma_abort  out  1  one-cycle pulse on watchdog expiry
- dma_done  in  1  engine completion pulse
- dma_err  in  1  engine error, qualified by dma_done

## Operation
- States: IDLE, ISSUE, WAIT, RELEASE.
- IDLE: if any req bit is set, pick the winner i, the first set bit searching upward from rr_ptr with wrap. Latch addr/len/wr[i], set gnt=1<<i. If req_len[i]==0, go to RELEASE with no DMA activity; otherwise go to ISSUE.
- ISSUE: dma_start=1 for exactly one cycle, clear the watchdog, go to WAIT. dma_done is ignored in ISSUE.
- WAIT: the watchdog increments each cycle.
  - dma_done=1: go to RELEASE and record dma_err.
  - Watchdog reaches TIMEOUT-1 with no dma_done: pulse dma_abort, record an error, go to RELEASE.
- RELEASE: done[i]=1 and err=recorded flag for one cycle. Clear gnt. Set rr_ptr=(i+1) mod NUM_REQ. Go to IDLE.
- Descriptors are sampled only in IDLE. Later changes to req_addr, req_len, req_wr, or deassertion of req[i] while granted, do not affect the transaction in flight.
- Requesters drop req in the cycle after done. A req still high then is treated as a new request and competes normally.
- No preemption; a new higher-priority req waits for RELEASE.

## Timing
- Reset values: gnt=0, done=0, err=0, dma_start=0, dma_abort=0, dma_addr=0, dma_len=0, dma_wr=0, rr_ptr=0, state IDLE, watchdog=0.
- Reset mid-transaction aborts silently: no done pulse and no dma_abort. The DMA engine is reset by the same rst_n.
- All outputs are registered.
- Latency: req rises before edge 0. gnt and dma_start are high after edge 0. dma_done at edge k gives done after edge k+1. The minimum grant is 3 cycles (ISSUE, WAIT, RELEASE).
- A zero-length request takes 2 cycles (grant, RELEASE) with no dma_start.
- Back-to-back: after RELEASE, IDLE costs one cycle before the next grant. There is no grant in the RELEASE cycle.
- dma_done and watchdog expiry in the same cycle: dma_done wins, no dma_abort, and err=dma_err.
- gnt is always one-hot or zero; done is only ever asserted on the bit matching gnt.

## Structure
- dma_pkg holds the arb_state_t enum (IDLE, ISSUE, WAIT, RELEASE) and the dma_desc_t struct {addr, len, wr}. It also holds the default widths, shared with the DMA controller and the sequencing FSMs.
- Sub-module rr_pick: a combinational round-robin priority encoder. Inputs are req and rr_ptr; outputs are a one-hot winner and a valid flag. It is reused by the output-buffer arbiter.

## Test plan
- Single request: req=0010, addr=0x1000, len=64; dma_done 10 cycles after dma_start -> gnt=0010 and dma_start for 1 cycle with dma_addr=0x1000 and dma_len=64; done=0010 one cycle after dma_done; err=0.
- Round-robin: req=1111 held continuously, each transfer completing immediately -> grant order 0001, 0010, 0100, 1000, 0001, and no requester is granted twice in a row.
- Zero length: req=0100, len=0 -> gnt 0100 for 2 cycles, done=0100, dma_start never asserted.
- Watchdog: TIMEOUT=16, dma_done never arrives -> dma_abort and err pulse; done pulses 17 cycles after dma_start; next pending request is granted afterwards.
- Error and collision: dma_done=1 with dma_err=1 -> err=1 with done. dma_done in the same cycle as watchdog expiry -> no dma_abort.
- Reset mid-WAIT: assert rst_n=0 -> all outputs 0 immediately. After release of reset, req=1000 with rr_ptr=0 -> granted 1000.
